// File: rtl/ftb_assoc_table_if.sv
// Lookup / prediction / update bundle for the set-associative fetch target buffer.
// Entry info layout (MSB..LSB): counter[1:0], carry, fallthru_addr, target_stat[1:0], target_addr.
`ifndef FTB_TAG_WIDTH
`define FTB_TAG_WIDTH 20
`endif

interface ftb_assoc_table_if #(
    parameter int XLEN       = 64,
    parameter int WAYS       = 4,
    parameter int FALLTHRU_W = 5,
    parameter int TARGET_W   = 12
);
    localparam int INFO_W = 5 + FALLTHRU_W + TARGET_W;
    localparam int WAY_W  = $clog2(WAYS);

    logic                   i_flush;
    logic                   i_lookup_vld;
    logic [XLEN-1:0]        i_lookup_pc;
    logic                   o_lookup_ready;
    logic                   o_pred_vld;
    logic                   o_pred_hit;
    logic                   o_pred_taken;
    logic [XLEN-1:0]        o_pred_npc;
    logic [INFO_W-1:0]      o_pred_info;
    logic [WAY_W-1:0]       o_pred_way;
    logic                   i_update_vld;
    logic [XLEN+INFO_W-1:0] i_update;
    logic                   i_update_taken;
    logic                   o_update_ready;

    modport master (
        output i_flush, i_lookup_vld, i_lookup_pc, i_update_vld, i_update, i_update_taken,
        input  o_lookup_ready, o_pred_vld, o_pred_hit, o_pred_taken, o_pred_npc,
               o_pred_info, o_pred_way, o_update_ready
    );

    modport slave (
        input  i_flush, i_lookup_vld, i_lookup_pc, i_update_vld, i_update, i_update_taken,
        output o_lookup_ready, o_pred_vld, o_pred_hit, o_pred_taken, o_pred_npc,
               o_pred_info, o_pred_way, o_update_ready
    );
endinterface

// File: rtl/ftb_assoc_table.sv
// Set-associative fetch target buffer: 1-cycle registered lookup, committed-branch updates,
// per-set round-robin replacement and a one-set-per-cycle invalidation sweep after reset/flush.
module ftb_assoc_table #(
    parameter int XLEN        = 64,
    parameter int SETS        = 256,
    parameter int WAYS        = 4,
    parameter int TAG_W       = `FTB_TAG_WIDTH,
    parameter int FETCH_BYTES = 32,
    parameter int FALLTHRU_W  = 5,
    parameter int TARGET_W    = 12
) (
    input logic           clk,
    input logic           rst,
    ftb_assoc_table_if.slave bus
);
    localparam int IDX_W   = $clog2(SETS);
    localparam int WAY_W   = $clog2(WAYS);
    localparam int INFO_W  = 5 + FALLTHRU_W + TARGET_W;
    localparam int CARRY_B = INFO_W - 3;
    localparam int FA_LSB  = TARGET_W + 2;
    localparam int FT_HI_W = XLEN - FALLTHRU_W - 1;
    localparam int TG_HI_W = XLEN - TARGET_W - 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    function automatic logic [WAY_W-1:0] pick_victim(input logic [WAYS-1:0] v,
                                                     input logic [WAY_W-1:0] rr);
        logic [WAY_W-1:0] pick;
        pick = rr;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!v[w]) pick = WAY_W'(w);
        return pick;
    endfunction

    state_t             state, state_nx;
    logic [IDX_W-1:0]   sweep_idx, sweep_idx_nx;
    logic [WAYS-1:0]    valid    [SETS];
    logic [WAY_W-1:0]   rr_ptr   [SETS];
    logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
    logic [INFO_W-1:0]  info_mem [SETS][WAYS];

    logic ready, lk_fire, up_fire;
    assign ready              = (state == S_RUN);
    assign lk_fire            = bus.i_lookup_vld & ready;
    assign up_fire            = bus.i_update_vld & ready;
    assign bus.o_lookup_ready = ready;
    assign bus.o_update_ready = ready;

    always_comb begin
        state_nx     = state;
        sweep_idx_nx = sweep_idx;
        case (state)
            S_INIT: begin
                if (bus.i_flush) begin
                    sweep_idx_nx = '0;
                end else if (sweep_idx == IDX_W'(SETS - 1)) begin
                    state_nx     = S_RUN;
                    sweep_idx_nx = '0;
                end else begin
                    sweep_idx_nx = sweep_idx + 1'b1;
                end
            end
            default: begin
                if (bus.i_flush) begin
                    state_nx     = S_INIT;
                    sweep_idx_nx = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_INIT;
            sweep_idx <= '0;
        end else begin
            state     <= state_nx;
            sweep_idx <= sweep_idx_nx;
        end
    end

    // Lookup path: set read, tag compare (lowest way wins), next-PC formation
    logic [XLEN-1:0]    lk_pc;
    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit, lk_taken;
    logic [WAY_W-1:0]   lk_way;
    logic [INFO_W-1:0]  lk_info;
    logic [FT_HI_W-1:0] ft_hi;
    logic [TG_HI_W-1:0] tg_hi;
    logic [XLEN-1:0]    ft_npc, tg_npc, miss_npc, lk_npc;

    assign lk_pc  = bus.i_lookup_pc;
    assign lk_idx = lk_pc[IDX_W+1:2];
    assign lk_tag = lk_pc[IDX_W+2 +: TAG_W];

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[lk_idx][w] && tag_mem[lk_idx][w] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
    end

    assign lk_info = info_mem[lk_idx][lk_way];
    assign ft_hi   = lk_pc[XLEN-1:FALLTHRU_W+1] + FT_HI_W'(lk_info[CARRY_B]);

    always_comb begin
        tg_hi = lk_pc[XLEN-1:TARGET_W+1];
        case (lk_info[TARGET_W +: 2])
            2'd1:    tg_hi = lk_pc[XLEN-1:TARGET_W+1] + TG_HI_W'(1);
            2'd2:    tg_hi = lk_pc[XLEN-1:TARGET_W+1] - TG_HI_W'(1);
            default: tg_hi = lk_pc[XLEN-1:TARGET_W+1];
        endcase
    end

    assign ft_npc   = {ft_hi, lk_info[FA_LSB +: FALLTHRU_W], 1'b0};
    assign tg_npc   = {tg_hi, lk_info[TARGET_W-1:0], 1'b0};
    assign miss_npc = (lk_pc & ~XLEN'(FETCH_BYTES - 1)) + XLEN'(FETCH_BYTES);
    assign lk_taken = lk_hit & lk_info[INFO_W-1];
    assign lk_npc   = !lk_hit ? miss_npc : (lk_taken ? tg_npc : ft_npc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.o_pred_vld   <= 1'b0;
            bus.o_pred_hit   <= 1'b0;
            bus.o_pred_taken <= 1'b0;
            bus.o_pred_npc   <= '0;
            bus.o_pred_info  <= '0;
            bus.o_pred_way   <= '0;
        end else begin
            bus.o_pred_vld <= lk_fire;
            if (lk_fire) begin
                bus.o_pred_hit   <= lk_hit;
                bus.o_pred_taken <= lk_taken;
                bus.o_pred_npc   <= lk_npc;
                bus.o_pred_info  <= lk_hit ? lk_info : '0;
                bus.o_pred_way   <= lk_hit ? lk_way : pick_victim(valid[lk_idx], rr_ptr[lk_idx]);
            end
        end
    end

    // Update path: hit refreshes info and steps the counter, miss allocates a victim
    logic [XLEN-1:0]   up_pc;
    logic [INFO_W-1:0] up_info, wr_info;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit, up_evict;
    logic [WAY_W-1:0]  up_way, up_victim, wr_way;
    logic [1:0]        wr_ctr;
    logic              unused_bits;

    assign up_pc   = bus.i_update[INFO_W +: XLEN];
    assign up_info = bus.i_update[INFO_W-1:0];
    assign up_idx  = up_pc[IDX_W+1:2];
    assign up_tag  = up_pc[IDX_W+2 +: TAG_W];
    assign unused_bits = ^{up_pc[XLEN-1:IDX_W+2+TAG_W], up_pc[1:0], up_info[INFO_W-1 -: 2]};

    always_comb begin
        up_hit = 1'b0;
        up_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[up_idx][w] && tag_mem[up_idx][w] == up_tag) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
        end
    end

    assign up_victim = pick_victim(valid[up_idx], rr_ptr[up_idx]);
    assign up_evict  = !up_hit && valid[up_idx][up_victim];
    assign wr_way    = up_hit ? up_way : up_victim;
    assign wr_ctr    = up_hit ? sat2(info_mem[up_idx][up_way][INFO_W-1 -: 2], bus.i_update_taken)
                              : (bus.i_update_taken ? 2'd2 : 2'd1);
    assign wr_info   = {wr_ctr, up_info[INFO_W-3:0]};

    always_ff @(posedge clk) begin
        if (up_fire) begin
            tag_mem[up_idx][wr_way]  <= up_tag;
            info_mem[up_idx][wr_way] <= wr_info;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                rr_ptr[s] <= '0;
            end
        end else if (state == S_INIT) begin
            valid[sweep_idx] <= '0;
        end else if (up_fire) begin
            valid[up_idx][wr_way] <= 1'b1;
            if (up_evict) rr_ptr[up_idx] <= rr_ptr[up_idx] + 1'b1;
        end
    end
endmodule
